pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value driven on out_data after reset.
REQ-003 SHALL have parameter FLUSH_CLEARS_DATA, default 1: 1 = flush loads RESET_VALUE into out_data; 0 = out_data keeps its value.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 R  input  1  reset; one clock, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  stage can accept; registered.
REQ-009 flush  input  1  discard all held and incoming payloads (bubble insert).
REQ-010 out_valid  output  1  out_data holds a valid payload.
REQ-011 out_data  output  WIDTH  payload from the main register.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-013 Input transfer SHALL occur on a posedge with in_valid=1 and in_ready=1; output transfer on a posedge with out_valid=1 and out_ready=1.
REQ-014 Storage SHALL be a main register plus one skid register; states EMPTY (none held), FULL (main held), SKID (main and skid held).
REQ-015 out_valid SHALL be 1 exactly in FULL and SKID; in_ready SHALL be 1 exactly in EMPTY and FULL.
REQ-016 EMPTY: in_valid=1 -> main<=in_data, go FULL; else stay.
REQ-017 FULL: out_ready=1, in_valid=0 -> EMPTY; out_ready=1, in_valid=1 -> main<=in_data, stay FULL; out_ready=0, in_valid=1 -> skid<=in_data, go SKID; both 0 -> stay.
REQ-018 SKID: out_ready=1 -> main<=skid, go FULL; out_ready=0 -> stay; in_data ignored (in_ready=0).
REQ-019 Latency in_data->out_data SHALL be 1 cycle from EMPTY; sustained throughput SHALL be 1 transfer/cycle with out_ready held 1.
REQ-020 Payloads SHALL leave in acceptance order; none duplicated or dropped except by flush or R.
REQ-021 out_data SHALL not change while out_valid=1 and out_ready=0.
REQ-022 flush=1 SHALL force EMPTY next cycle; an input or output handshake in the flush cycle SHALL be void (payload discarded, not counted).
REQ-023 flush with FLUSH_CLEARS_DATA=1 SHALL load RESET_VALUE into main and skid; with 0 they keep values while out_valid=0.
REQ-024 R SHALL take priority over flush; flush over all handshakes.

Reset
REQ-025 On posedge with R=1: state EMPTY, out_valid=0, in_ready=1, out_data=RESET_VALUE, skid=RESET_VALUE, performance counters 0.
REQ-026 R asserted in SKID or FULL SHALL discard both payloads with no output transfer in that cycle.
REQ-027 First input transfer SHALL be possible on the first posedge after R falls.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_PERF_EN defined: SHALL add outputs stall_cycles[15:0] (increments each posedge with out_valid=1, out_ready=0, saturates at 16'hFFFF) and xfer_count[15:0] (increments per output transfer, wraps at 16'hFFFF->0); both cleared by R, not by flush.
REQ-029 Macro undefined: ports stall_cycles and xfer_count and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 R=1 one cycle then 0 -> out_valid=0, in_ready=1, out_data=32'h0; in_data=32'hA5A5_0001, in_valid=1 one cycle -> next cycle out_valid=1, out_data=32'hA5A5_0001.
REQ-031 out_ready=0, push 32'h11, 32'h22 -> after second push in_ready=0 (SKID), out_data=32'h11; out_ready=1 two cycles -> outputs 32'h11 then 32'h22, then EMPTY, in_ready=1.
REQ-032 Stream 32'h1..32'h64 with out_ready=1 continuously -> 100 outputs in order on 100 consecutive cycles, in_ready never 0.
REQ-033 In SKID (32'h33, 32'h44 held), flush=1 with in_valid=1, in_data=32'h55 -> next cycle out_valid=0, out_data=RESET_VALUE, 32'h55 never output.
REQ-034 flush and R same cycle in FULL -> R result per REQ-025; with PIPE_STAGE_SKID_PERF_EN, 3 stall cycles then 1 transfer -> stall_cycles=3, xfer_count=1; flush leaves them unchanged.
REQ-035 WIDTH=8, RESET_VALUE=8'hFF, FLUSH_CLEARS_DATA=0: reset -> out_data=8'hFF; load 8'h12, flush -> out_valid=0, out_data=8'h12.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with a main and a skid register, flush and registered ready.
// Define PIPE_STAGE_SKID_PERF_EN to add the stall_cycles and xfer_count performance counters.
module pipe_stage_skid #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             R,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      xfer_count
`endif
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    state_t state;
    logic [WIDTH-1:0] skid;
    always_ff @(posedge clk) begin
        if (R) begin
            state <= EMPTY;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            out_data <= RESET_VALUE;
            skid <= RESET_VALUE;
        end else if (flush) begin
            state <= EMPTY;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            if (FLUSH_CLEARS_DATA) begin
                out_data <= RESET_VALUE;
                skid <= RESET_VALUE;
            end
        end else begin
            case (state)
                EMPTY: if (in_valid) begin
                    out_data <= in_data;
                    state <= FULL;
                    out_valid <= 1'b1;
                end
                FULL: if (out_ready && !in_valid) begin
                    state <= EMPTY;
                    out_valid <= 1'b0;
                end else if (out_ready) begin
                    out_data <= in_data;
                end else if (in_valid) begin
                    skid <= in_data;
                    state <= SKID;
                    in_ready <= 1'b0;
                end
                SKID: if (out_ready) begin
                    out_data <= skid;
                    state <= FULL;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
`ifdef PIPE_STAGE_SKID_PERF_EN
    // Counters ignore flush cycles so a bubble insert leaves them untouched.
    always_ff @(posedge clk) begin
        if (R) begin
            stall_cycles <= '0;
            xfer_count <= '0;
        end else if (!flush) begin
            if (out_valid && !out_ready && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
            if (out_valid && out_ready) xfer_count <= xfer_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed plus random checks of pipe_stage_skid against a queue-based model.
module tb_pipe_stage_skid;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic R, in_valid, flush, out_ready, in_ready, out_valid;
    logic [31:0] in_data, out_data;
    logic b_R, b_in_valid, b_flush, b_out_ready, b_in_ready, b_out_valid;
    logic [7:0] b_in_data, b_out_data;
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [15:0] stall_cycles, xfer_count, b_stall_cycles, b_xfer_count;
`endif

    pipe_stage_skid dut (
        .clk(clk), .R(R), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef PIPE_STAGE_SKID_PERF_EN
        , .stall_cycles(stall_cycles), .xfer_count(xfer_count)
`endif
    );

    pipe_stage_skid #(.WIDTH(8), .RESET_VALUE(8'hFF), .FLUSH_CLEARS_DATA(1'b0)) dut_b (
        .clk(clk), .R(b_R), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .flush(b_flush), .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready)
`ifdef PIPE_STAGE_SKID_PERF_EN
        , .stall_cycles(b_stall_cycles), .xfer_count(b_xfer_count)
`endif
    );

    logic [31:0] q[$];
    logic [31:0] held;
    int stall_m, xfer_m;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic verify();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("out_data", out_data, q.size() > 0 ? q[0] : held);
`ifdef PIPE_STAGE_SKID_PERF_EN
        chk("stall_cycles", {16'd0, stall_cycles}, stall_m);
        chk("xfer_count", {16'd0, xfer_count}, xfer_m);
`endif
    endtask

    // Queue model: holds at most two payloads, accepts when not full, pops when downstream ready.
    task automatic step(input logic r, input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic acc, pop;
        R = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        @(posedge clk);
        if (r) begin
            q.delete(); held = 32'h0; stall_m = 0; xfer_m = 0;
        end else if (fl) begin
            q.delete(); held = 32'h0;
        end else begin
            acc = iv && q.size() < 2;
            pop = ordy && q.size() > 0;
            if (q.size() > 0 && !ordy && stall_m < 65535) stall_m++;
            if (pop) begin
                xfer_m = (xfer_m + 1) % 65536;
                held = q.pop_front();
            end
            if (acc) q.push_back(d);
        end
        #1;
        verify();
    endtask

    initial begin
        R = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        b_R = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        held = 32'h0; stall_m = 0; xfer_m = 0;

        step(1, 0, 0, 0, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'h0);
        step(0, 1, 32'hA5A5_0001, 0, 0);
        chk("first_out_valid", {31'd0, out_valid}, 32'd1);
        chk("first_out_data", out_data, 32'hA5A5_0001);
        step(0, 0, 0, 1, 0);

        step(0, 1, 32'h11, 0, 0);
        step(0, 1, 32'h22, 0, 0);
        chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_out_data", out_data, 32'h11);
        step(0, 0, 0, 1, 0);
        chk("skid_drain1", out_data, 32'h22);
        step(0, 0, 0, 1, 0);
        chk("skid_drain_empty", {31'd0, in_ready, out_valid}, 32'd2);

        for (int i = 1; i <= 100; i++) begin
            step(0, 1, i, 1, 0);
            chk("stream_data", out_data, i);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        step(0, 0, 0, 1, 0);

        step(0, 1, 32'h33, 0, 0);
        step(0, 1, 32'h44, 0, 0);
        step(0, 1, 32'h55, 1, 1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_data", out_data, 32'h0);
        step(0, 0, 0, 1, 0);
        chk("flush_no_55", {31'd0, out_valid}, 32'd0);

        step(0, 1, 32'h77, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flush_data", out_data, 32'h0);
        step(0, 1, 32'h88, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h99, 0, 0);
        step(0, 0, 0, 0, 1);
`ifdef PIPE_STAGE_SKID_PERF_EN
        chk("perf_stall", {16'd0, stall_cycles}, 32'd3);
        chk("perf_xfer", {16'd0, xfer_count}, 32'd1);
`endif

        for (int i = 0; i < 500; i++)
            step($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom,
                 $urandom_range(2) != 0, $urandom_range(15) == 0);

        @(posedge clk); #1;
        b_R = 1'b0;
        chk("b_rst_data", {24'd0, b_out_data}, 32'hFF);
        chk("b_rst_valid", {31'd0, b_out_valid}, 32'd0);
        b_in_valid = 1'b1; b_in_data = 8'h12;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("b_load_data", {24'd0, b_out_data}, 32'h12);
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        chk("b_flush_valid", {31'd0, b_out_valid}, 32'd0);
        chk("b_flush_data", {24'd0, b_out_data}, 32'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
